cardinal_nic: RTL and testbench

//  Network interface controller on the PE side of one mesh node. Bridges a processor

---
 rtl/cardinal_nic.sv | 127 ++++++++++++
 tb/tb_cardinal_nic.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// cardinal_nic: PE-side network interface of one mesh node.
// Bridges a processor load/store port to the router PE link through a
// 1-entry output (processor->network) and a 1-entry input (network->processor)
// channel buffer, each with a full flag the processor can poll.
module cardinal_nic #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,        // asynchronous, active-low
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    output logic              net_si,
    input  logic              net_ri,
    output logic [DATA_W-1:0] net_di,
    input  logic              net_so,
    output logic              net_ro,
    input  logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    localparam logic [1:0] ADDR_IBUF   = 2'd0;
    localparam logic [1:0] ADDR_ISTAT  = 2'd1;
    localparam logic [1:0] ADDR_OBUF   = 2'd2;
    localparam logic [1:0] ADDR_OSTAT  = 2'd3;

    logic [DATA_W-1:0] obuf_q, obuf_d;
    logic              obuf_full_q, obuf_full_d;
    logic [DATA_W-1:0] ibuf_q, ibuf_d;
    logic              ibuf_full_q, ibuf_full_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;

    logic proc_wr;
    logic proc_rd;
    logic eject;

    // Processor access decode; a store into a full output buffer is dropped.
    assign proc_wr = nicEn & nicWrEn & (addr == ADDR_OBUF) & ~obuf_full_q;
    assign proc_rd = nicEn & ~nicWrEn;

    // Injection only when the router is ready and the packet VC bit matches
    // the router's current polarity; otherwise the packet waits and retries.
    assign net_si = obuf_full_q & net_ri & (obuf_q[DATA_W-1] == net_polarity);
    assign net_di = obuf_q;

    // Ready for eject only out of reset and with the input buffer empty, so a
    // read-clear and a new eject can never land on the same edge.
    assign net_ro = reset & ~ibuf_full_q;
    assign eject  = net_so & net_ro;

    // Output channel next state: a send empties, an accepted store fills.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        obuf_d      = obuf_q;
        obuf_full_d = obuf_full_q;
        if (net_si) begin
            obuf_full_d = 1'b0;
        end else if (proc_wr) begin
            obuf_d      = d_in;
            obuf_full_d = 1'b1;
        end
    end

    // Input channel next state: eject fills, a read of address 0 clears the flag.
    always_comb begin
        ibuf_d      = ibuf_q;
        ibuf_full_d = ibuf_full_q;
        if (eject) begin
            ibuf_d      = net_do;
            ibuf_full_d = 1'b1;
        end else if (proc_rd && (addr == ADDR_IBUF)) begin
            ibuf_full_d = 1'b0;
        end
    end

    // Read data mux; d_out holds when there is no read access.
    always_comb begin
        d_out_d = d_out_q;
        if (proc_rd) begin
            unique case (addr)
                ADDR_IBUF:  d_out_d = ibuf_q;
                ADDR_ISTAT: d_out_d = {{(DATA_W-1){1'b0}}, ibuf_full_q};
                ADDR_OBUF:  d_out_d = '0;
                ADDR_OSTAT: d_out_d = {{(DATA_W-1){1'b0}}, obuf_full_q};
                default:    d_out_d = '0;
            endcase
        end
    end

    // Output channel registers.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the data buffers are reset too, since a read of an empty input buffer returns its stale contents and must be deterministic.
        if (!reset) begin
            obuf_q      <= '0;
            obuf_full_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            obuf_q      <= obuf_d;
            obuf_full_q <= obuf_full_d;
        end
    end

    // Input channel registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ibuf_q      <= '0;
            ibuf_full_q <= 1'b0;
        end else begin
            ibuf_q      <= ibuf_d;
            ibuf_full_q <= ibuf_full_d;
        end
    end

    // Registered processor read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out_q <= '0;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios followed by random
// traffic, all compared against a queue-based model of the two channels.
module tb_cardinal_nic;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   addr;
    logic [W-1:0] d_in;
    logic [W-1:0] d_out;
    logic         nicEn;
    logic         nicWrEn;
    logic         net_si;
    logic         net_ri;
    logic [W-1:0] net_di;
    logic         net_so;
    logic         net_ro;
    logic [W-1:0] net_do;
    logic         net_polarity;

    cardinal_nic #(.DATA_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int sends    = 0;

    // Reference model: each channel is a queue of at most one packet.
    logic [W-1:0] oq[$];
    logic [W-1:0] iq[$];
    logic [W-1:0] ibuf_last = '0;
    logic [W-1:0] exp_dout  = '0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic wr, input logic [1:0] a,
                         input logic [W-1:0] din, input logic ri, input logic pol,
                         input logic so, input logic [W-1:0] pkt);
        nicEn = en; nicWrEn = wr; addr = a; d_in = din;
        net_ri = ri; net_polarity = pol; net_so = so; net_do = pkt;
    endtask

    task automatic idle(input logic ri, input logic pol);
        drive(1'b0, 1'b0, 2'd0, '0, ri, pol, 1'b0, '0);
    endtask

    // One clock: called just after a negedge with inputs applied. Checks the
    // combinational link outputs, advances the model across the edge, then
    // checks the registered read data; returns at the next negedge.
    task automatic step();
        logic         exp_si;
        logic         exp_ro;
        int           o_n;
        int           i_n;
        o_n    = oq.size();
        i_n    = iq.size();
        exp_si = (o_n == 1) && net_ri && (oq[0][W-1] == net_polarity);
        exp_ro = (i_n == 0);
        #1;
        check("net_si", {63'd0, net_si}, {63'd0, exp_si});
        check("net_ro", {63'd0, net_ro}, {63'd0, exp_ro});
        if (exp_si) check("net_di", net_di, oq[0]);
        if (net_si) sends++;
        // Read data is taken from pre-edge state.
        if (nicEn && !nicWrEn) begin
            case (addr)
                2'd0: exp_dout = ibuf_last;
                2'd1: exp_dout = W'(i_n);
                2'd2: exp_dout = '0;
                default: exp_dout = W'(o_n);
            endcase
        end
        if (exp_si) void'(oq.pop_front());
        else if (nicEn && nicWrEn && addr == 2'd2 && o_n == 0) oq.push_back(d_in);
        if (net_so && i_n == 0) begin
            iq.push_back(net_do);
            ibuf_last = net_do;
        end else if (nicEn && !nicWrEn && addr == 2'd0 && i_n == 1) begin
            void'(iq.pop_front());
        end
        @(posedge clk);
        #1;
        check("d_out", d_out, exp_dout);
        @(negedge clk);
    endtask

    task automatic model_reset();
        oq.delete();
        iq.delete();
        ibuf_last = '0;
        exp_dout  = '0;
    endtask

    int s0;

    initial begin
        reset = 1'b0;
        idle(1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_d_out", d_out, '0);
        check("rst_si", {63'd0, net_si}, '0);
        check("rst_ro", {63'd0, net_ro}, '0);
        @(negedge clk);
        reset = 1'b1;

        // T1: reset asserted with both buffers full.
        drive(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_0077, 1'b0, 1'b0, 1'b1, 64'h55);
        step();
        drive(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, 1'b0, '0);
        step();
        check("t1_ifull", d_out, 64'd1);
        reset = 1'b0;
        drive(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 1'b0, '0);
        model_reset();
        #1;
        check("t1_si", {63'd0, net_si}, '0);
        check("t1_ro", {63'd0, net_ro}, '0);
        check("t1_dout", d_out, '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t1_ro_rel", {63'd0, net_ro}, 64'd1);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd3, '0, 1'b1, 1'b0, 1'b0, '0);
        step();
        check("t1_ostat", d_out, '0);
        drive(1'b1, 1'b0, 2'd1, '0, 1'b1, 1'b0, 1'b0, '0);
        step();
        check("t1_istat", d_out, '0);

        // T2: store then immediate inject.
        drive(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_00A5, 1'b1, 1'b0, 1'b0, '0);
        step();
        idle(1'b1, 1'b0);
        #1;
        check("t2_si", {63'd0, net_si}, 64'd1);
        check("t2_di", net_di, 64'h0000_0000_0000_00A5);
        step();
        drive(1'b1, 1'b0, 2'd3, '0, 1'b1, 1'b0, 1'b0, '0);
        step();
        check("t2_ostat", d_out, '0);

        // T3: odd-VC packet, polarity toggling each cycle.
        drive(1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b0, '0);
        step();
        s0 = sends;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1, i[0] ? 1'b1 : 1'b0);
            step();
        end
        check("t3_sends", 64'(sends - s0), 64'd1);

        // T4: second store dropped while the first waits on net_ri=0.
        drive(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_0011, 1'b0, 1'b0, 1'b0, '0);
        step();
        drive(1'b1, 1'b1, 2'd2, 64'h0000_0000_0000_00FF, 1'b0, 1'b0, 1'b0, '0);
        step();
        s0 = sends;
        idle(1'b1, 1'b0);
        #1;
        check("t4_di", net_di, 64'h0000_0000_0000_0011);
        step();
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, 1'b0);
            step();
        end
        check("t4_sends", 64'(sends - s0), 64'd1);

        // T5: eject, poll status, read-clear.
        drive(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 64'h1234);
        step();
        idle(1'b0, 1'b0);
        #1;
        check("t5_ro_busy", {63'd0, net_ro}, '0);
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd1, '0, 1'b0, 1'b0, 1'b0, '0);
        step();
        check("t5_istat", d_out, 64'd1);
        drive(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, '0);
        step();
        check("t5_data", d_out, 64'h1234);
        idle(1'b0, 1'b0);
        #1;
        check("t5_ro_free", {63'd0, net_ro}, 64'd1);
        @(negedge clk);

        // T6: router keeps offering; second packet waits for the clear.
        drive(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 64'hAAAA);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 64'hBBBB);
            step();
        end
        drive(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 64'hBBBB);
        step();
        check("t6_first", d_out, 64'hAAAA);
        drive(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b1, 64'hBBBB);
        step();
        drive(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, 1'b0, '0);
        step();
        check("t6_second", d_out, 64'hBBBB);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  2'($urandom_range(0, 3)), {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, {$urandom, $urandom});
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
